// File: rtl/uart_host_pkg.sv
// Shared opcodes, command-type and state encodings, and frame/reply length
// lookups for the UART command host.
package uart_host_pkg;

   localparam logic [7:0] WR_CMD      = 8'hAA;
   localparam logic [7:0] RD_CMD      = 8'hBB;
   localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
   localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

   localparam logic [1:0] CMD_WR      = 2'b00;
   localparam logic [1:0] CMD_RD      = 2'b01;
   localparam logic [1:0] CMD_ALU_OP  = 2'b10;
   localparam logic [1:0] CMD_ALU_NOP = 2'b11;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SEND     = 2'd1;
   localparam logic [1:0] ST_WAIT_RSP = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   typedef struct packed {
      logic [1:0] ctype;
      logic [3:0] addr;
      logic [7:0] data;
      logic [7:0] opb;
      logic [3:0] fun;
   } cmd_t;

   // Index of the final frame byte (frame length minus one).
   function automatic logic [1:0] frame_last(input logic [1:0] ctype);
      case (ctype)
         CMD_WR:     frame_last = 2'd2;
         CMD_RD:     frame_last = 2'd1;
         CMD_ALU_OP: frame_last = 2'd3;
         default:    frame_last = 2'd1;
      endcase
   endfunction

   function automatic logic [1:0] reply_len(input logic [1:0] ctype);
      case (ctype)
         CMD_WR:  reply_len = 2'd0;
         CMD_RD:  reply_len = 2'd1;
         default: reply_len = 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/uart_host_timer.sv
// Clearable, enabled up-counter that flags when it sits on its terminal value.
module uart_host_timer #(
   parameter int          W    = 16,
   parameter int unsigned TERM = 49999
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic term
);

   logic [W-1:0] count_q, count_d;

   assign term = (count_q == W'(TERM));

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en && !term)
         count_d = count_q + W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side UART command engine: frames one command to the TX sink and
// assembles the reply. Response timeout is built only with UART_HOST_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | ready for a command
// ST_SEND     | presenting frame[idx] to the TX sink
// ST_WAIT_RSP | collecting reply bytes, LSB first
// ST_DONE     | one-cycle result pulse
module uart_cmd_host
   import uart_host_pkg::*;
#(
   parameter int TIMEOUT_W = 16,
   parameter int TIMEOUT   = 50000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [3:0]  cmd_addr,
   input  logic [7:0]  cmd_data,
   input  logic [7:0]  cmd_opb,
   input  logic [3:0]  cmd_fun,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_timeout,
   output logic        busy
);

   logic [1:0]  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [1:0]  rx_cnt_q, rx_cnt_d;
   cmd_t        cmd_q, cmd_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        timeout_q, timeout_d;
   logic        timer_term;
   logic [7:0]  frame_byte;

`ifdef UART_HOST_TIMEOUT_EN
   uart_host_timer #(
      .W    (TIMEOUT_W),
      .TERM (TIMEOUT - 1)
   ) u_timer (
      .CLK  (CLK),
      .RST  (RST),
      .clr  ((state_q != ST_WAIT_RSP) || rx_valid),
      .en   (state_q == ST_WAIT_RSP),
      .term (timer_term)
   );
`else
   assign timer_term = 1'b0;
`endif

   always_comb begin
      frame_byte = 8'h00;
      case (cmd_q.ctype)
         CMD_WR: begin
            case (idx_q)
               2'd0:    frame_byte = WR_CMD;
               2'd1:    frame_byte = {4'h0, cmd_q.addr};
               default: frame_byte = cmd_q.data;
            endcase
         end
         CMD_RD:
            frame_byte = (idx_q == 2'd0) ? RD_CMD : {4'h0, cmd_q.addr};
         CMD_ALU_OP: begin
            case (idx_q)
               2'd0:    frame_byte = ALU_OP_CMD;
               2'd1:    frame_byte = cmd_q.data;
               2'd2:    frame_byte = cmd_q.opb;
               default: frame_byte = {4'h0, cmd_q.fun};
            endcase
         end
         default:
            frame_byte = (idx_q == 2'd0) ? ALU_NOP_CMD : {4'h0, cmd_q.fun};
      endcase
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rx_cnt_d   = rx_cnt_q;
      cmd_d      = cmd_q;
      rsp_data_d = rsp_data_q;
      timeout_d  = timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               cmd_d      = '{ctype: cmd_type, addr: cmd_addr, data: cmd_data,
                              opb: cmd_opb, fun: cmd_fun};
               idx_d      = 2'd0;
               rx_cnt_d   = 2'd0;
               rsp_data_d = 16'h0000;
               timeout_d  = 1'b0;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               if (idx_q == frame_last(cmd_q.ctype))
                  state_d = (reply_len(cmd_q.ctype) == 2'd0) ? ST_DONE : ST_WAIT_RSP;
               else
                  idx_d = idx_q + 2'd1;
            end
         end
         ST_WAIT_RSP: begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (rx_valid) begin
               if (rx_cnt_q == 2'd0)
                  rsp_data_d[7:0] = rx_byte;
               else
                  rsp_data_d[15:8] = rx_byte;
               rx_cnt_d = rx_cnt_q + 2'd1;
               if ((rx_cnt_q + 2'd1) == reply_len(cmd_q.ctype))
                  state_d = ST_DONE;
            end else if (timer_term) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         idx_q      <= 2'd0;
         rx_cnt_q   <= 2'd0;
         cmd_q      <= '0;
         rsp_data_q <= 16'h0000;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rx_cnt_q   <= rx_cnt_d;
         cmd_q      <= cmd_d;
         rsp_data_q <= rsp_data_d;
         timeout_q  <= timeout_d;
      end
   end

   // Handshake outputs are masked while RST is high so nothing transfers during reset.
   assign cmd_ready   = (state_q == ST_IDLE) && !RST;
   assign tx_valid    = (state_q == ST_SEND) && !RST;
   assign tx_byte     = tx_valid ? frame_byte : 8'h00;
   assign rsp_valid   = (state_q == ST_DONE) && !RST;
   assign rsp_timeout = rsp_valid && timeout_q;
   assign rsp_data    = rsp_data_q;
   assign busy        = (state_q != ST_IDLE) && !RST;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Randomized self-checking bench for uart_cmd_host against a transaction-level
// model of frames, reply assembly and response timing.
module tb_uart_cmd_host;

   localparam int TIMEOUT = 20;
`ifdef UART_HOST_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam logic [1:0] T_WR = 2'b00, T_RD = 2'b01, T_OP = 2'b10, T_NOP = 2'b11;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_type;
   logic [3:0]  cmd_addr, cmd_fun;
   logic [7:0]  cmd_data, cmd_opb;
   logic [7:0]  tx_byte, rx_byte;
   logic        tx_valid, tx_ready, rx_valid;
   logic        rsp_valid, rsp_timeout, busy;
   logic [15:0] rsp_data;

   int checks = 0;
   int errors = 0;

   uart_cmd_host #(.TIMEOUT_W(16), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_opb(cmd_opb), .cmd_fun(cmd_fun),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_byte(rx_byte), .rx_valid(rx_valid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic abort_with_reset();
      RST = 1'b1;
      #1;
      check_val("rst_tx_valid", tx_valid, 0);
      check_val("rst_cmd_ready", cmd_ready, 0);
      check_val("rst_rsp_valid", rsp_valid, 0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check_val("rst_rel_ready", cmd_ready, 1);
      check_val("rst_rel_busy", busy, 0);
      check_val("rst_rel_tx_valid", tx_valid, 0);
   endtask

   // mode: 0 tx_ready always high, 1 toggling 1/0, 2 random.
   // nrep: reply bytes actually delivered; gap: idle cycles before each (-1 random).
   task automatic run_cmd(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] d,
                          input logic [7:0] b, input logic [3:0] f, input int mode,
                          input int nrep, input logic [7:0] r0, input logic [7:0] r1,
                          input int gap);
      logic [7:0]  frame[$];
      logic [7:0]  reps[2];
      logic [15:0] exp_data;
      logic        exp_to, done, rdy, fire;
      int          need, k, cyc, got, idle, cur_gap, watch;

      reps[0] = r0;
      reps[1] = r1;
      frame = {};
      case (t)
         T_WR:    begin frame.push_back(8'hAA); frame.push_back({4'h0, addr}); frame.push_back(d); end
         T_RD:    begin frame.push_back(8'hBB); frame.push_back({4'h0, addr}); end
         T_OP:    begin frame.push_back(8'hCC); frame.push_back(d); frame.push_back(b);
                        frame.push_back({4'h0, f}); end
         default: begin frame.push_back(8'hDD); frame.push_back({4'h0, f}); end
      endcase
      need = (t == T_WR) ? 0 : (t == T_RD) ? 1 : 2;

      check_val("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_type  = t; cmd_addr = addr; cmd_data = d; cmd_opb = b; cmd_fun = f;
      rx_valid  = 1'($urandom_range(0, 1));
      rx_byte   = 8'($urandom);
      @(negedge CLK);
      cmd_valid = 1'b0;
      cmd_type  = 2'($urandom); cmd_addr = 4'($urandom); cmd_data = 8'($urandom);
      cmd_opb   = 8'($urandom); cmd_fun = 4'($urandom);

      k = 0;
      cyc = 0;
      while (k < frame.size() && cyc < 200) begin
         check_val("tx_valid", tx_valid, 1);
         check_val("tx_byte", tx_byte, frame[k]);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2) == 0;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         tx_ready = rdy;
         rx_valid = 1'($urandom_range(0, 1));
         rx_byte  = 8'($urandom);
         @(negedge CLK);
         if (rdy) k++;
         cyc++;
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      check_val("tx_frame_done", 16'(k), 16'(frame.size()));

      exp_data = 16'h0000;
      exp_to   = 1'b0;
      done     = (need == 0);
      got      = 0;
      idle     = 0;
      watch    = 0;
      cur_gap  = (gap < 0) ? $urandom_range(0, TIMEOUT - 1) : gap;
      while (!done && watch < 4 * TIMEOUT + 10) begin
         check_val("rsp_early", rsp_valid, 0);
         fire = (got < nrep) && (idle == cur_gap);
         rx_valid = fire;
         rx_byte  = fire ? reps[got] : 8'($urandom);
         @(negedge CLK);
         watch++;
         if (fire) begin
            exp_data[8*got +: 8] = reps[got];
            got++;
            idle = 0;
            cur_gap = (gap < 0) ? $urandom_range(0, TIMEOUT - 1) : gap;
            if (got == need) done = 1'b1;
         end else begin
            idle++;
            if (TO_EN && idle == TIMEOUT) begin
               exp_to = 1'b1;
               done   = 1'b1;
            end
         end
      end
      rx_valid = 1'b0;

      if (done) begin
         check_val("rsp_valid", rsp_valid, 1);
         check_val("rsp_data", rsp_data, exp_data);
         check_val("rsp_timeout", rsp_timeout, exp_to);
         rx_valid = 1'($urandom_range(0, 1));
         rx_byte  = 8'($urandom);
         @(negedge CLK);
         rx_valid = 1'b0;
         check_val("rsp_pulse_len", rsp_valid, 0);
         check_val("turnaround_ready", cmd_ready, 1);
      end else begin
         check_val("wait_hang_busy", busy, 1);
         abort_with_reset();
      end
   endtask

   task automatic reset_mid_command();
      check_val("mid_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_type = T_RD; cmd_addr = 4'h7; cmd_data = 8'h00; cmd_opb = 8'h00; cmd_fun = 4'h0;
      @(negedge CLK);
      cmd_valid = 1'b0;
      check_val("mid_byte0", tx_byte, 8'hBB);
      tx_ready = 1'b1;
      @(negedge CLK);
      tx_ready = 1'b0;
      check_val("mid_byte1_valid", tx_valid, 1);
      check_val("mid_byte1", tx_byte, 8'h07);
      tx_ready = 1'b1;
      abort_with_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rx_valid = 1'b1;
         rx_byte  = 8'($urandom);
         @(negedge CLK);
         check_val("mid_no_rsp", rsp_valid, 0);
         check_val("mid_idle_tx", tx_valid, 0);
      end
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [1:0] t;
      int         nr;
      RST = 1'b1;
      cmd_valid = 1'b0; cmd_type = 2'b00; cmd_addr = 4'h0; cmd_data = 8'h00;
      cmd_opb = 8'h00; cmd_fun = 4'h0; tx_ready = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
      repeat (3) @(negedge CLK);
      check_val("reset_cmd_ready", cmd_ready, 0);
      check_val("reset_tx_valid", tx_valid, 0);
      check_val("reset_tx_byte", tx_byte, 8'h00);
      check_val("reset_rsp_valid", rsp_valid, 0);
      check_val("reset_rsp_data", rsp_data, 16'h0000);
      check_val("reset_rsp_timeout", rsp_timeout, 0);
      check_val("reset_busy", busy, 0);
      RST = 1'b0;
      @(negedge CLK);

      run_cmd(T_WR,  4'h4, 8'h5A, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, -1);
      run_cmd(T_RD,  4'h2, 8'h00, 8'h00, 4'h0, 0, 1, 8'h81, 8'h00, 0);
      run_cmd(T_OP,  4'h0, 8'h10, 8'h03, 4'h0, 1, 2, 8'h13, 8'h00, 2);
      run_cmd(T_NOP, 4'h0, 8'h00, 8'h00, 4'h2, 0, 1, 8'h30, 8'h00, 1);
      reset_mid_command();
      run_cmd(T_RD,  4'h9, 8'h00, 8'h00, 4'h0, 0, 1, 8'hE7, 8'h00, TIMEOUT - 1);
      run_cmd(T_NOP, 4'h0, 8'h00, 8'h00, 4'h5, 2, 2, 8'h3C, 8'hA5, TIMEOUT - 1);
      run_cmd(T_OP,  4'h0, 8'h01, 8'h02, 4'h3, 0, 0, 8'h00, 8'h00, 0);

      for (int n = 0; n < 40; n++) begin
         t  = 2'($urandom);
         nr = (t == T_WR) ? 0 : (t == T_RD) ? 1 : 2;
         if ($urandom_range(0, 7) == 0 && nr > 0) nr = nr - 1;
         run_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                 2, nr, 8'($urandom), 8'($urandom), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
